cla_8bit: RTL and testbench

//  - N-bit carry-lookahead adder (default 8 bits).
//  - Computes S = A + B + c_in with carry-out, using two-level lookahead:
//    bit-level generate/propagate, then group-level generate/propagate.
//  - Result and carry-out are registered once on clk.
//  - Leaf arithmetic block for datapaths needing a fast, fixed-latency add.

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_4bit_block.sv | 40 ++++
 rtl/cla_8bit.sv | 79 +++++++
 tb/tb_cla_8bit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and the group generate/propagate helper for the
// carry-lookahead adder family.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  typedef struct packed {
    logic gg;
    logic gp;
  } cla_gp_t;

  // Group generate/propagate of a 4-bit slice from its bit-level g/p vectors.
  function automatic cla_gp_t cla_group_gp(input logic [3:0] g, input logic [3:0] p);
    cla_gp_t r;
    r.gg = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    r.gp = p[3] & p[2] & p[1] & p[0];
    return r;
  endfunction

endpackage

// File: rtl/cla_4bit_block.sv
// 4-bit lookahead slice: sum bits from a flattened in-group carry network,
// plus group generate/propagate for the next lookahead level.
module cla_4bit_block
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       gg,
  output logic       gp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  cla_gp_t    grp;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a two-level sum of products from cin; nothing ripples.
  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

  assign grp = cla_group_gp(g, p);
  assign gg  = grp.gg;
  assign gp  = grp.gp;

endmodule

// File: rtl/cla_8bit.sv
// N-bit two-level carry-lookahead adder with a single registered result
// stage: {c_out, S} = A + B + c_in, one cycle after the operands are sampled.
module cla_8bit
  import cla_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c_in,
  output logic [N-1:0] S,
  output logic         c_out
);

  localparam int NG = N / CLA_GROUP;

  if ((N % CLA_GROUP) != 0 || N < CLA_GROUP) begin : g_bad_width
    $error("cla_8bit: N must be a positive multiple of 4");
  end

  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   grp_c;
  logic [N-1:0]  sum;

  for (genvar j = 0; j < NG; j++) begin : g_block
    cla_4bit_block u_block (
      .a   (A[j*CLA_GROUP +: CLA_GROUP]),
      .b   (B[j*CLA_GROUP +: CLA_GROUP]),
      .cin (grp_c[j]),
      .s   (sum[j*CLA_GROUP +: CLA_GROUP]),
      .gg  (gg[j]),
      .gp  (gp[j])
    );
  end

  if (N == 8) begin : g_carry8
    assign grp_c[0] = c_in;
    assign grp_c[1] = gg[0]
                    | (gp[0] & c_in);
    assign grp_c[2] = gg[1]
                    | (gp[1] & gg[0])
                    | (gp[1] & gp[0] & c_in);
  end else begin : g_carry_n
    logic acc;
    logic prod;

    // Each group carry is built as the flat OR of GG[k] gated by the AND of
    // all GP above it, so the loops unroll into a sum of products, not a chain.
    always_comb begin
      grp_c    = '0;
      acc      = 1'b0;
      prod     = 1'b1;
      grp_c[0] = c_in;
      for (int j = 0; j < NG; j++) begin
        acc  = 1'b0;
        prod = 1'b1;
        for (int k = j; k >= 0; k--) begin
          acc  = acc | (prod & gg[k]);
          prod = prod & gp[k];
        end
        grp_c[j+1] = acc | (prod & c_in);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S     <= '0;
      c_out <= 1'b0;
    end else begin
      S     <= sum;
      c_out <= grp_c[NG];
    end
  end

endmodule

// File: tb/tb_cla_8bit.sv
// Directed and random checks of cla_8bit: reset, 1-cycle latency, group
// carry boundaries, and back-to-back adds against a behavioural sum.
module tb_cla_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       c_in;
  logic [7:0] S;
  logic       c_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] last_exp;
  bit         have_last;

  typedef struct {
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[16];

  cla_8bit #(.N(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .c_in  (c_in),
    .S     (S),
    .c_out (c_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {c_out,S}=%h expected %h", name, got, exp);
    end
  endtask

  // Drive one operand set, confirm the output has not moved before the edge,
  // then compare the registered result just after the edge.
  task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [8:0] exp, input string name);
    logic [8:0] want;
    @(negedge clk);
    rst  = r;
    A    = a;
    B    = b;
    c_in = ci;
    exp_q.push_back(exp);
    #1;
    if (have_last) check({name, "_hold"}, {c_out, S}, last_exp);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(name, {c_out, S}, want);
    last_exp  = want;
    have_last = 1'b1;
  endtask

  function automatic logic [8:0] ref_add(input logic r, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
    if (r) return 9'h000;
    return {1'b0, a} + {1'b0, b} + {8'h00, ci};
  endfunction

  initial begin
    rst       = 1'b1;
    A         = 8'h00;
    B         = 8'h00;
    c_in      = 1'b0;
    have_last = 1'b0;
    last_exp  = '0;

    vecs[0]  = '{1'b1, 8'hAA, 8'h55, 1'b1, 9'h000};
    vecs[1]  = '{1'b1, 8'hFF, 8'hFF, 1'b1, 9'h000};
    vecs[2]  = '{1'b0, 8'd5,  8'd10, 1'b0, 9'h00F};
    vecs[3]  = '{1'b0, 8'd30, 8'hF6, 1'b0, 9'h114};
    vecs[4]  = '{1'b0, 8'd5,  8'd10, 1'b1, 9'h010};
    vecs[5]  = '{1'b0, 8'd127, 8'hFF, 1'b0, 9'h17E};
    vecs[6]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 9'h100};
    vecs[7]  = '{1'b0, 8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[8]  = '{1'b0, 8'h80, 8'h80, 1'b0, 9'h100};
    vecs[9]  = '{1'b0, 8'h0F, 8'h01, 1'b0, 9'h010};
    vecs[10] = '{1'b0, 8'h0F, 8'h00, 1'b1, 9'h010};
    vecs[11] = '{1'b0, 8'hF0, 8'h0F, 1'b1, 9'h100};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 1'b0, 9'h000};
    vecs[13] = '{1'b1, 8'h12, 8'h34, 1'b0, 9'h000};
    vecs[14] = '{1'b0, 8'h12, 8'h34, 1'b0, 9'h046};
    vecs[15] = '{1'b0, 8'h7F, 8'h01, 1'b0, 9'h080};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp,
            $sformatf("vec%0d", i));
    end

    // Back-to-back boundary pair, then reset mid-stream and recover.
    drive(1'b0, 8'hFF, 8'h00, 1'b1, 9'h100, "seq_ff_p1");
    drive(1'b0, 8'hFF, 8'hFF, 1'b1, 9'h1FF, "seq_ff_ff1");
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 9'h000, "seq_rst");
    drive(1'b0, 8'h01, 8'h02, 1'b0, 9'h003, "seq_after_rst");

    // Random back-to-back stream with occasional resets.
    for (int i = 0; i < 1200; i++) begin
      logic       r;
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      r  = ($urandom_range(0, 49) == 0);
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      ci = 1'($urandom_range(0, 1));
      drive(r, a, b, ci, ref_add(r, a, b, ci), r ? "rand_rst" : "rand");
    end

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
